instr_mem_loader: RTL

//  Field-to-word instruction encoder plus sequential loader for the single-cycle CPU's instruction memory.
//  - Accepts one instruction per handshake as separate fields.
//  - Packs the fields into the CPU's 32-bit instruction format.
//  - Writes the packed words to consecutive instruction-memory addresses.
//  - Holds the CPU in hold until the program is complete.

---
 rtl/instr_mem_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Field-to-word instruction encoder and sequential instruction-RAM loader.
// Optional feature: define HALT_APPEND_EN to append a halt word after the last instruction.
module instr_mem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic [1:0]        inKind,
    input  logic [3:0]        inAluCmd,
    input  logic [4:0]        inSelA,
    input  logic [4:0]        inSelB,
    input  logic [4:0]        inSelW,
    input  logic [15:0]       inImm,
    input  logic              inLast,
    input  logic              start,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memData,
    output logic              memWE,
    output logic              cpuHold,
    output logic              loadDone,
    output logic              errOverflow,
    output logic [ADDR_W:0]   wordCount
);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
`ifdef HALT_APPEND_EN
    localparam logic [2:0] S_HALTW = 3'd2;
`endif
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [31:0]       HALT_WORD = 32'h0000_0003;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic              at_max;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   cnt_inc;

    function automatic logic [31:0] encode(
        input logic [1:0]  kind,
        input logic [3:0]  alu,
        input logic [4:0]  sa,
        input logic [4:0]  sb,
        input logic [4:0]  sw,
        input logic [15:0] imm
    );
        logic [31:0] w;
        case (kind)
            2'b00:   w = {sb, 11'b0, sa, sw, alu, kind};
            2'b01:   w = {imm, sa, sw, alu, kind};
            2'b10:   w = {imm, 14'b0, kind};
            default: w = HALT_WORD;
        endcase
        return w;
    endfunction

    assign at_max   = (addr_q == ADDR_MAX);
    assign addr_inc = addr_q + ADDR_W'(1);
    assign cnt_inc  = cnt_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOAD: begin
                if (inValid) begin
                    data_d  = encode(inKind, inAluCmd, inSelA,
                                     inSelB, inSelW, inImm);
                    last_d  = inLast;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_inc;
                // Address saturates at the top of memory; overflow never wraps.
                if (!at_max) addr_d = addr_inc;
                if (last_q) begin
`ifdef HALT_APPEND_EN
                    if (at_max) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_HALTW;
                        data_d  = HALT_WORD;
                    end
`else
                    state_d = S_DONE;
`endif
                end else if (at_max) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef HALT_APPEND_EN
            S_HALTW: begin
                cnt_d   = cnt_inc;
                if (!at_max) addr_d = addr_inc;
                state_d = S_DONE;
            end
`endif
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
`ifdef HALT_APPEND_EN
        memWE = (state_q == S_WRITE) || (state_q == S_HALTW);
`else
        memWE = (state_q == S_WRITE);
`endif
        inReady     = (state_q == S_LOAD);
        loadDone    = (state_q == S_DONE);
        cpuHold     = (state_q != S_DONE);
        errOverflow = (state_q == S_ERROR);
    end

    assign memAddr   = addr_q;
    assign memData   = data_q;
    assign wordCount = cnt_q;

endmodule
